// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the two-requester BRAM port arbiter.
// The tag type records one pipelined read response slot.
package mem_port_arbiter_pkg;

    localparam int DEF_AW     = 10;
    localparam int DEF_DW     = 16;
    localparam int DEF_RD_LAT = 1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a one-bit priority pointer.
// Grants are combinational; the pointer flips to the loser on every grant.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    // r_fav1 = 0 favours requester 0 on contention
    logic r_fav1;

    always_comb begin
        o_gnt0 = ~reset & i_req0 & (~i_req1 | ~r_fav1);
        o_gnt1 = ~reset & i_req1 & (~i_req0 |  r_fav1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fav1 <= 1'b0;
        end else if (o_gnt0) begin
            r_fav1 <= 1'b1;
        end else if (o_gnt1) begin
            r_fav1 <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one BRAM port between two requesters; reads return RD_LAT cycles
// after acceptance on the shared rdata bus, tagged by per-requester rvalid.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic w_gnt0;
    logic w_gnt1;
    logic w_win_id;
    logic w_rd_accept;
    tag_t r_tag [RD_LAT];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_req0 (req0),
        .i_req1 (req1),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    always_comb begin
        w_win_id    = w_gnt1 ? REQ1 : REQ0;
        mem_en      = w_gnt0 | w_gnt1;
        mem_we      = w_gnt1 ? we1 : (w_gnt0 & we0);
        mem_addr    = w_gnt1 ? addr1 : addr0;
        mem_din     = w_gnt1 ? wdata1 : wdata0;
        w_rd_accept = mem_en & ~mem_we;
    end

    // Tag shift register tracks BRAM read latency; reset drops every in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_rd_accept, id: w_win_id};
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = ~reset & r_tag[RD_LAT-1].valid & (r_tag[RD_LAT-1].id == REQ0);
    assign rvalid1 = ~reset & r_tag[RD_LAT-1].valid & (r_tag[RD_LAT-1].id == REQ1);
    assign rdata   = mem_dout;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the 1024x16 block RAM between two independent requesters, e.g. the switch/button front end and a fill/scan engine.
- Requesters issue single-word read or write transactions with a req/gnt handshake.
- A round-robin arbiter picks one requester per cycle and drives the BRAM port.
- Read data returns to the granted requester after a fixed BRAM latency, tagged by a per-requester valid pulse.

Parameters:
- AW, 10, address width (1024 words)
- DW, 16, data width
- RD_LAT, 1, BRAM read latency in cycles (1 = no output register, 2 = output register enabled); legal range 1..3

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 transaction request
- we0  in  1  requester 0 write (1) / read (0)
- addr0  in  AW  requester 0 address
- wdata0  in  DW  requester 0 write data
- gnt0  out  1  requester 0 transaction accepted this cycle
- rvalid0  out  1  requester 0 read data valid (1-cycle pulse)
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as above, for requester 1
- rdata  out  DW  read data, shared; qualified by rvalid0/rvalid1
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  AW  BRAM address
- mem_din  out  DW  BRAM write data
- mem_dout  in  DW  BRAM read data

Behaviour:
- Reset values:
  - gnt0 = gnt1 = 0 while reset is high.
  - rvalid0 = rvalid1 = 0.
  - Priority pointer = requester 0 favoured.
  - Read tag pipeline cleared.
  - mem_en = mem_we = 0.
  - rdata passes mem_dout through and is don't-care when no rvalid is asserted.
- Handshake:
  - A requester asserts req with we/addr/wdata valid and holds all of them stable until it sees gnt in the same cycle.
  - A transaction is accepted on the rising edge where req && gnt.
  - Back-to-back requests are allowed: req may stay high after gnt to issue the next transaction.
- Grant (combinational, from req0, req1, pointer):
  - Only one requester asserting req: it gets gnt.
  - Both asserting: the requester the pointer favours gets gnt.
  - Neither asserting: no gnt, mem_en = 0.
  - gnt0 and gnt1 are never both high.
- Pointer: updated on every grant to favour the requester that was not granted. Under continuous contention the grants strictly alternate 0,1,0,1...
- BRAM drive (combinational from the winner):
  - mem_en = gnt0 | gnt1.
  - mem_we = winner's we.
  - mem_addr and mem_din = winner's addr and wdata.
- Write: completes at the accept edge and produces no response. A read of the same address in any later cycle returns the new data.
- Read tag pipeline:
  - RD_LAT stages; each stage holds {valid, id}.
  - Stage 0 loads {gnt & ~we, winner id}.
  - rvalidN = last stage valid && id == N.
  - rvalid is asserted exactly RD_LAT cycles after the accept edge; rdata = mem_dout in that cycle.
- Pipelining: a read can be accepted every cycle. Responses return in accept order. No stall or backpressure on responses; requesters must always accept rvalid.
- Reset mid-operation: all in-flight reads are discarded and no rvalid is produced for them. The pointer returns to requester 0.
- Simultaneous write (req0) and read (req1) of the same address in the same cycle: only one is granted. The read returns old or new data according to grant order, never a mix.
- Address arithmetic: none. Addresses pass through unchanged and there is no wrap logic in this block.

Decomposition:
- Shared package/header holds AW, DW, the requester ID constants REQ0 = 0 and REQ1 = 1, and the default RD_LAT.
- One natural sub-module: rr_arbiter2, the 2-way round-robin grant logic plus pointer register.
- Tag pipeline and BRAM mux stay in the top module.

Test Plan:
- Reset, then req0 writes 0xBEEF to addr 5; next cycle req0 reads addr 5 -> gnt0 same cycle each time; rvalid0 exactly RD_LAT cycles after read accept; rdata = 0xBEEF; rvalid1 stays 0.
- req0 and req1 both held high for 8 cycles, all reads of addrs 0..7 pre-loaded with addr*0x11 -> grants alternate 0,1,0,1...; every rvalid matches its requester with the correct data, in order.
- req1 alone issues 16 back-to-back reads -> gnt1 high all 16 cycles; 16 consecutive rvalid1 pulses; addrs 0x3F0..0x3FF return the expected contents.
- Same cycle: req0 writes 0x1234 and req1 reads addr 9 (old value 0x0000), pointer favouring 0 -> write granted first; the read returns 0x1234. Repeat with pointer favouring 1 -> read returns 0x0000.
- Reads in flight with RD_LAT = 2, reset asserted one cycle after accept -> no rvalid ever for those reads; after reset the pointer favours requester 0.
- Idle (no req) for 10 cycles -> mem_en = 0, no gnt, no rvalid, pointer unchanged.
